noc_input_buffer: RTL
=====================

Name: noc_input_buffer

Overview:
- Per-direction input stage of the router; one instance per port (L, N, E, W, S).
- Buffers incoming flits in a small FIFO and tracks packet framing.
- Drives the request, flit_id and length lines that the output arbiter consumes.
- Forwards flits to the crossbar one per cycle while its port holds the grant.

Parameters:
- DEPTH, 4, FIFO depth in flits; power of two, minimum 2.
- DATA_W, 32, flit width. Bits [DATA_W-1:DATA_W-3] are flit_id; bits [11:0] of a header flit are the packet length in flits.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- in_flit  input  DATA_W  flit from upstream link.
- in_valid  input  1  in_flit is valid.
- in_ready  output  1  buffer can accept; transfer happens when in_valid && in_ready.
- grant  input  1  arbiter currently selects this port.
- req  output  1  request to arbiter.
- flit_id  output  3  id of head flit: 3'b001 header, 3'b010 body, 3'b100 tail; 3'b000 when empty.
- length  output  12  packet length; low 12 bits of the head flit when it is a header, else the last latched header length.
- out_flit  output  DATA_W  head flit to crossbar.
- out_valid  output  1  out_flit popped this cycle.
- occupancy  output  log2(DEPTH)+1  flits currently stored.

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, pointers 0, occupancy 0, state IDLE, length register 0; req=0, out_valid=0, flit_id=000, in_ready=1.
- FIFO:
  - Circular buffer with wrap-around read/write pointers and an explicit count.
  - in_ready = (count < DEPTH); a push at full is impossible by design.
  - Simultaneous push and pop: count unchanged. At full with a pop, in_ready stays 0 that cycle (registered full flag, no combinational bypass).
  - Push to an empty FIFO: flit is visible at the head the next cycle (1-cycle latency).
- flit_id and out_flit are combinational from the head entry. length is combinational from the head when it is a header; otherwise it is taken from the latched register.
- Pop occurs when state=XFER && grant && count>0. out_flit is registered: out_valid=1 and out_flit equal the popped entry one cycle after the pop.
- FSM:
  - IDLE: req=0.
    - Head is a header: go to REQ and latch length.
    - Head is body/tail (framing error): pop and discard it, stay IDLE, out_valid=0.
  - REQ: req=1; go to XFER when grant=1.
  - XFER: req=1; pop one flit per cycle while grant=1 and FIFO non-empty.
    - Empty FIFO mid-packet: hold in XFER, req stays 1, no pop.
    - grant drops mid-packet (arbiter timeout): stop popping, stay in XFER with req=1, resume when grant returns. Packets are never interleaved.
    - Popping the tail: go to IDLE next cycle, req=0 for at least one cycle.
    - Single-flit packet: a header with length==1 is treated as header+tail.
- Length counter: 12-bit remaining-flit count, loaded from the header, decremented per pop. If it reaches 0 before the tail, the next flit is treated as terminating: go to IDLE and the excess flits are discarded as framing errors.
- Reset mid-packet clears everything immediately; partially transferred packets are lost.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> in_ready=1, req=0, occupancy=0, flit_id=000; no pushes accepted.
- Normal packet: push header(len=3), body, tail with grant=1 from the cycle req rises -> req rises 1 cycle after the header push, length=3, flit_id=001; out_valid high 3 consecutive cycles with flits in order; req=0 the cycle after the tail pops.
- Full/backpressure: DEPTH=4, grant=0, push 5 flits -> in_ready=0 after 4, occupancy=4; raise grant -> one pop/cycle, in_ready returns, 5th flit accepted, no loss or duplication.
- Grant drop: 6-flit packet, drop grant after 2 pops for 5 cycles -> no pops, req stays 1, flit_id=010; resumes with the 3rd flit when grant returns.
- Framing error: push body flit to an empty buffer -> discarded, req stays 0, occupancy returns to 0; a following header is handled normally.
- Reset mid-packet: assert rst after 1 of 3 flits popped -> occupancy=0, req=0 asynchronously; a new packet after reset completes correctly.

Source files
------------

// File: rtl/noc_input_buffer.sv
// Router input stage for one port: flit FIFO, packet-framing FSM and arbiter request.
// Granted flits leave through a registered output stage, one per cycle.
module noc_input_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_W-1:0]      in_flit,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   grant,
    output logic                   req,
    output logic [2:0]             flit_id,
    output logic [11:0]            length,
    output logic [DATA_W-1:0]      out_flit,
    output logic                   out_valid,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] ID_HDR  = 3'b001;
    localparam logic [2:0] ID_TAIL = 3'b100;
    localparam logic [2:0] ID_NONE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_XFER = 2'b10
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_next_s;
    logic [11:0]       len_r;
    logic [11:0]       rem_r;
    logic              in_ready_r;
    logic              req_r;
    logic              out_valid_r;
    logic [DATA_W-1:0] out_flit_r;
    logic [DATA_W-1:0] head_s;
    logic [2:0]        head_id_s;
    logic              head_valid_s;
    logic              head_is_hdr_s;
    logic              push_s;
    logic              pop_s;
    logic              fwd_s;
    logic              last_s;
    logic              start_s;

    // Head-of-queue decode and input handshake
    always_comb begin
        head_s        = mem_r[rd_ptr_r];
        head_valid_s  = (count_r != {CNT_W{1'b0}});
        head_id_s     = head_s[DATA_W-1 -: 3];
        head_is_hdr_s = head_valid_s && (head_id_s == ID_HDR);
        push_s        = in_valid && in_ready_r;
    end

    // Next-state logic of the framing FSM
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (head_is_hdr_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (grant) begin
                    state_next_s = ST_XFER;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_XFER: begin
                if (fwd_s && last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_XFER;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: forward, discard and packet-start strobes
    always_comb begin
        fwd_s   = 1'b0;
        pop_s   = 1'b0;
        start_s = 1'b0;
        // The pop that exhausts the length counter ends the packet even without a tail
        last_s  = (head_id_s == ID_TAIL) || (rem_r <= 12'd1);
        case (state_r)
            ST_IDLE: begin
                start_s = head_is_hdr_s;
                pop_s   = head_valid_s && !head_is_hdr_s;
            end
            ST_REQ: begin
                pop_s = 1'b0;
            end
            ST_XFER: begin
                fwd_s = grant && head_valid_s;
                pop_s = fwd_s;
            end
            default: begin
                pop_s = 1'b0;
            end
        endcase
    end

    // Occupancy update for simultaneous push/pop
    always_comb begin
        count_next_s = count_r;
        if (push_s && !pop_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_next_s = count_r - CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // FIFO pointers, count and registered ready flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            in_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_next_s;
            in_ready_r <= (count_next_s < CNT_W'(DEPTH));
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= in_flit;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Latched header length and remaining-flit counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_r <= 12'd0;
            rem_r <= 12'd0;
        end else if (start_s) begin
            len_r <= head_s[11:0];
            rem_r <= head_s[11:0];
        end else if (fwd_s && (rem_r != 12'd0)) begin
            rem_r <= rem_r - 12'd1;
        end
    end

    // Registered request and crossbar output stage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_flit_r  <= {DATA_W{1'b0}};
        end else begin
            req_r       <= (state_next_s != ST_IDLE);
            out_valid_r <= fwd_s;
            if (fwd_s) begin
                out_flit_r <= head_s;
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign req       = req_r;
    assign out_valid = out_valid_r;
    assign out_flit  = out_flit_r;
    assign occupancy = count_r;
    assign flit_id   = head_valid_s ? head_id_s : ID_NONE;
    assign length    = head_is_hdr_s ? head_s[11:0] : len_r;

endmodule
